// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Multi-cycle RV32M execution unit for the EX stage. Multiplies with an
// iterative shift-add datapath and divides with a restoring divider, one
// iteration per clock, on operand magnitudes with a sign fix-up at the end.
//
// Ports:
//   clk_i     clock, all state updates on the rising edge
//   reset_i   synchronous active-high reset
//   start_i   request, sampled only in IDLE
//   abort_i   pipeline flush, cancels an in-flight operation
//   select_i  ALU operation code (M-extension codes handled here)
//   data1_i   rs1 operand, sampled with start_i
//   data2_i   rs2 operand, sampled with start_i
//   busy_o    high while iterating (stall request)
//   done_o    one-cycle result-valid pulse
//   result_o  result, valid only while done_o=1, otherwise 0
//
// Configuration macro: DIV_FAST_SPECIAL_EN
//   defined   : divide-by-zero and signed overflow finish straight from IDLE
//   undefined : those cases run all iterations; result overridden at the end
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [4:0]       select_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  // M-extension SELECT codes (mirror utils/encordings.v)
  localparam logic [4:0] SEL_MUL    = 5'd16;
  localparam logic [4:0] SEL_MULH   = 5'd17;
  localparam logic [4:0] SEL_MULHSU = 5'd18;
  localparam logic [4:0] SEL_MULHU  = 5'd19;
  localparam logic [4:0] SEL_DIV    = 5'd20;
  localparam logic [4:0] SEL_DIVU   = 5'd21;
  localparam logic [4:0] SEL_REM    = 5'd22;
  localparam logic [4:0] SEL_REMU   = 5'd23;

  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH-1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;           // {hi, lo}: product, or {remainder, quotient}
  logic [WIDTH-1:0]   m_q, m_d;           // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   spec_res_q, spec_res_d;
  logic               spec_q, spec_d;
  logic               is_div_q, is_div_d;
  logic               hi_q, hi_d;
  logic               want_rem_q, want_rem_d;
  logic               neg_q, neg_d;       // negate product / quotient
  logic               neg_rem_q, neg_rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Two's-complement negate when n is set
  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? (~v + ONE) : v;
  endfunction

  // Opcode decode and operand preparation, used only on the accept cycle
  logic             is_m_s, is_div_s, hi_s, want_rem_s, a_sgn_s, b_sgn_s;
  logic             a_neg_s, b_neg_s, div0_s, ovf_s, special_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s, spec_res_s;

  // Decode SELECT into operation class and operand signedness
  always_comb begin
    is_m_s     = 1'b1;
    is_div_s   = 1'b0;
    hi_s       = 1'b0;
    want_rem_s = 1'b0;
    a_sgn_s    = 1'b0;
    b_sgn_s    = 1'b0;
    case (select_i)
      SEL_MUL:    hi_s = 1'b0;  // low half is sign-agnostic
      SEL_MULH:   begin hi_s = 1'b1; a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
      SEL_MULHSU: begin hi_s = 1'b1; a_sgn_s = 1'b1; end
      SEL_MULHU:  hi_s = 1'b1;
      SEL_DIV:    begin is_div_s = 1'b1; a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
      SEL_DIVU:   is_div_s = 1'b1;
      SEL_REM:    begin is_div_s = 1'b1; want_rem_s = 1'b1; a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
      SEL_REMU:   begin is_div_s = 1'b1; want_rem_s = 1'b1; end
      default:    is_m_s = 1'b0;
    endcase
  end

  assign a_neg_s    = a_sgn_s & data1_i[WIDTH-1];
  assign b_neg_s    = b_sgn_s & data2_i[WIDTH-1];
  assign a_mag_s    = neg_if(a_neg_s, data1_i);
  assign b_mag_s    = neg_if(b_neg_s, data2_i);
  assign div0_s     = (data2_i == ZERO);
  assign ovf_s      = a_sgn_s & (data1_i == MIN_NEG) & (data2_i == ALL_ONES);
  assign special_s  = is_div_s & (div0_s | ovf_s);
  assign spec_res_s = div0_s ? (want_rem_s ? data1_i : ALL_ONES)
                             : (want_rem_s ? ZERO : MIN_NEG);

  // One iteration of the shift-add multiplier and the restoring divider
  logic [WIDTH:0]     mul_sum_s, div_sh_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic               div_borrow_s;
  logic [2*WIDTH-1:0] mul_nx_s, div_nx_s, p_nx_s, prod_s;
  logic [WIDTH-1:0]   fin_s;

  assign mul_sum_s    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
  assign mul_nx_s     = {mul_sum_s, p_q[WIDTH-1:1]};
  // Shift {rem, quo} left by one; the remainder absorbs the quotient MSB.
  assign div_sh_s     = p_q[2*WIDTH-1:WIDTH-1];
  assign div_borrow_s = (div_sh_s < {1'b0, m_q});
  // Low-half subtraction is exact: without borrow the difference is < divisor.
  assign div_diff_s   = div_sh_s[WIDTH-1:0] - m_q;
  assign div_nx_s     = div_borrow_s ? {div_sh_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                     : {div_diff_s, p_q[WIDTH-2:0], 1'b1};
  assign p_nx_s       = is_div_q ? div_nx_s : mul_nx_s;
  assign prod_s       = neg_q ? (~p_nx_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : p_nx_s;

  // Final result from the last iteration, with special cases overriding
  always_comb begin
    if (spec_q) begin
      fin_s = spec_res_q;
    end else if (is_div_q) begin
      fin_s = want_rem_q ? neg_if(neg_rem_q, p_nx_s[2*WIDTH-1:WIDTH])
                         : neg_if(neg_q, p_nx_s[WIDTH-1:0]);
    end else begin
      fin_s = hi_q ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    m_d        = m_q;
    spec_res_d = spec_res_q;
    spec_d     = spec_q;
    is_div_d   = is_div_q;
    hi_d       = hi_q;
    want_rem_d = want_rem_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    result_d   = ZERO;
    case (state_q)
      IDLE: begin
        if (abort_i) begin
          state_d = IDLE;  // flush drops a same-cycle request
        end else if (start_i) begin
          if (!is_m_s) begin
            state_d = FIN;
`ifdef DIV_FAST_SPECIAL_EN
          end else if (special_s) begin
            state_d  = FIN;
            result_d = spec_res_s;
`endif
          end else begin
            state_d    = RUN;
            cnt_d      = {CNT_W{1'b0}};
            p_d        = {ZERO, (is_div_s ? a_mag_s : b_mag_s)};
            m_d        = is_div_s ? b_mag_s : a_mag_s;
            spec_res_d = spec_res_s;
            spec_d     = special_s;
            is_div_d   = is_div_s;
            hi_d       = hi_s;
            want_rem_d = want_rem_s;
            neg_d      = a_neg_s ^ b_neg_s;
            neg_rem_d  = a_neg_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          p_d   = p_nx_s;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d  = FIN;
            result_d = fin_s;
          end else begin
            state_d = RUN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      p_q        <= {(2*WIDTH){1'b0}};
      m_q        <= ZERO;
      spec_res_q <= ZERO;
      spec_q     <= 1'b0;
      is_div_q   <= 1'b0;
      hi_q       <= 1'b0;
      want_rem_q <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= ZERO;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      m_q        <= m_d;
      spec_res_q <= spec_res_d;
      spec_q     <= spec_d;
      is_div_q   <= is_div_d;
      hi_q       <= hi_d;
      want_rem_q <= want_rem_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
